fetch_sequencer: RTL

Control block for the fetch stage. Owns the fetch stage's `pcWrEn`/`newPc` redirect port and decides each cycle whether fetch advances sequentially, takes a branch, loops back in hardware, or is parked. Provides a `flush` qualifier to the fetch/decode pipeline register so wrong-path instructions are squashed. It sits between execute/decode (redirect and halt sources) and the fetch stage.

---
 rtl/fetch_sequencer.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/fetch_sequencer.sv
// Fetch-stage control: decides each cycle whether fetch runs sequentially, redirects to a branch
// or loop target, or is parked in IDLE/HALT. All outputs are registered.
// Optional hardware loop support is built when FETCH_HWLOOP_EN is defined.
module fetch_sequencer #(
  parameter int unsigned InstSize = 24,
  localparam int unsigned AW = InstSize + 8
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic          start_i,
  input  logic [AW-1:0] fetch_pc_i,
  input  logic          branch_en_i,
  input  logic [AW-1:0] branch_target_i,
  input  logic          halt_inst_i,
  input  logic [AW-1:0] halt_pc_i,
  input  logic          loop_set_i,
  input  logic [AW-1:0] loop_begin_i,
  input  logic [AW-1:0] loop_end_i,
  input  logic [15:0]   loop_count_i,
  output logic          pc_wr_en_o,
  output logic [AW-1:0] new_pc_o,
  output logic          flush_o,
  output logic          running_o,
  output logic          halted_o,
  output logic          loop_active_o
);

  typedef enum logic [1:0] {StIdle, StRun, StRedir, StHalt} state_e;

  state_e        state_q;
  logic          pc_wr_en_q;
  logic [AW-1:0] new_pc_q;
  logic          flush_q;
  logic          running_q;
  logic          halted_q;

  logic          loop_back;
  logic [AW-1:0] loop_pc;
  logic [AW-1:0] redir_pc;

`ifdef FETCH_HWLOOP_EN
  logic [AW-1:0] loop_begin_q;
  logic [AW-1:0] loop_end_q;
  logic [15:0]   remaining_q;
  logic          loop_active_q;

  // Loop-back only fires from RUN when no higher-priority event or reprogramming is pending.
  assign loop_back = (state_q == StRun) && !halt_inst_i && !branch_en_i && !loop_set_i &&
                     loop_active_q && (fetch_pc_i == loop_end_q) && (remaining_q > 16'd1);
  assign loop_pc   = loop_begin_q;

  // Loop registers: programming wins over a same-cycle decrement.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      loop_begin_q  <= '0;
      loop_end_q    <= '0;
      remaining_q   <= '0;
      loop_active_q <= 1'b0;
    end else if (loop_set_i) begin
      loop_begin_q  <= loop_begin_i;
      loop_end_q    <= loop_end_i;
      remaining_q   <= loop_count_i;
      loop_active_q <= (loop_count_i > 16'd1);
    end else if (loop_back) begin
      remaining_q   <= remaining_q - 16'd1;
      loop_active_q <= (remaining_q > 16'd2);
    end
  end

  assign loop_active_o = loop_active_q;
`else
  logic unused_loop_inputs;
  assign unused_loop_inputs = ^{fetch_pc_i, loop_set_i, loop_begin_i, loop_end_i, loop_count_i};
  assign loop_back     = 1'b0;
  assign loop_pc       = '0;
  assign loop_active_o = 1'b0;
`endif

  // Redirect target: a branch always beats a loop-back.
  always_comb begin
    redir_pc = loop_pc;
    if (branch_en_i) redir_pc = branch_target_i;
  end

  // Sequencer FSM with registered redirect/flush/status outputs.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q    <= StIdle;
      pc_wr_en_q <= 1'b1;
      new_pc_q   <= '0;
      flush_q    <= 1'b1;
      running_q  <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q    <= StRun;
            pc_wr_en_q <= 1'b0;
            flush_q    <= 1'b0;
            running_q  <= 1'b1;
          end
        end
        StRun: begin
          if (halt_inst_i) begin
            state_q    <= StHalt;
            pc_wr_en_q <= 1'b1;
            new_pc_q   <= halt_pc_i;
            flush_q    <= 1'b1;
            running_q  <= 1'b0;
            halted_q   <= 1'b1;
          end else if (branch_en_i || loop_back) begin
            state_q    <= StRedir;
            pc_wr_en_q <= 1'b1;
            new_pc_q   <= redir_pc;
            flush_q    <= 1'b1;
            running_q  <= 1'b0;
          end else begin
            pc_wr_en_q <= 1'b0;
            flush_q    <= 1'b0;
          end
        end
        StRedir: begin
          // Halt here is wrong-path; only a fresh branch re-enters REDIR.
          if (branch_en_i) begin
            new_pc_q <= branch_target_i;
          end else begin
            state_q    <= StRun;
            pc_wr_en_q <= 1'b0;
            flush_q    <= 1'b1;  // squashes the slot fetched before the delayed redirect lands
            running_q  <= 1'b1;
          end
        end
        StHalt: ;
        default: state_q <= StIdle;
      endcase
    end
  end

  assign pc_wr_en_o = pc_wr_en_q;
  assign new_pc_o   = new_pc_q;
  assign flush_o    = flush_q;
  assign running_o  = running_q;
  assign halted_o   = halted_q;

endmodule
